// File: rtl/key_mode_sel.sv
// Button front end for the LED blinker: synchronise, debounce, short press steps
// the blink mode, long hold forces mode 0; mode is mapped to led_en and cnt_max.
module key_mode_sel #(
    parameter logic [19:0] DB_MAX   = 20'd999999,
    parameter logic [26:0] LONG_MAX = 27'd99999999,
    parameter logic [24:0] CNT_M1   = 25'd24999999,
    parameter logic [24:0] CNT_M2   = 25'd12499999,
    parameter logic [24:0] CNT_M3   = 25'd2499999
) (
    input  logic        clk50m,
    input  logic        rst,
    input  logic        key_n,
    output logic        press_pulse,
    output logic        long_pulse,
    output logic [1:0]  mode,
    output logic        led_en,
    output logic [24:0] cnt_max
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [1:0]  sync_reg;
    logic        ks;
    logic [1:0]  state_reg, state_next;
    logic [19:0] db_reg, db_next;
    logic [26:0] hold_reg, hold_next;
    logic [1:0]  mode_reg, mode_next;
    logic        press_reg, press_next;
    logic        long_reg, long_next;
    logic        led_en_reg, led_en_next;
    logic [24:0] cnt_max_reg, cnt_max_next;

    // Two-flop synchroniser; both stages idle high (button released).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk50m or posedge rst) begin
                if (rst)
                    sync_reg[gi] <= 1'b1;
                else if (gi == 0)
                    sync_reg[gi] <= key_n;
                else
                    sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign ks = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        db_next    = db_reg;
        hold_next  = hold_reg;
        mode_next  = mode_reg;
        press_next = 1'b0;
        long_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!ks) begin
                    state_next = PRESS_WAIT;
                    db_next    = '0;
                end
            end
            PRESS_WAIT: begin
                if (ks) begin
                    state_next = IDLE;
                    db_next    = '0;
                end else if (db_reg == DB_MAX) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                    hold_next  = '0;
                    mode_next  = mode_reg + 2'd1;
                end else begin
                    db_next = db_reg + 20'd1;
                end
            end
            PRESSED: begin
                if (ks) begin
                    state_next = RELEASE_WAIT;
                    db_next    = '0;
                end else if (hold_reg != LONG_MAX) begin
                    // Saturation at LONG_MAX guarantees a single long strobe per hold.
                    hold_next = hold_reg + 27'd1;
                    if (hold_reg == LONG_MAX - 27'd1) begin
                        long_next = 1'b1;
                        mode_next = 2'd0;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (!ks)
                    state_next = PRESSED;
                else if (db_reg == DB_MAX)
                    state_next = IDLE;
                else
                    db_next = db_reg + 20'd1;
            end
            default: begin
                state_next = IDLE;
                db_next    = '0;
            end
        endcase
    end

    always_comb begin
        led_en_next  = (mode_next != 2'd0);
        cnt_max_next = CNT_M1;
        case (mode_next)
            2'd2:    cnt_max_next = CNT_M2;
            2'd3:    cnt_max_next = CNT_M3;
            default: cnt_max_next = CNT_M1;
        endcase
    end

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            db_reg      <= '0;
            hold_reg    <= '0;
            mode_reg    <= 2'd0;
            press_reg   <= 1'b0;
            long_reg    <= 1'b0;
            led_en_reg  <= 1'b0;
            cnt_max_reg <= CNT_M1;
        end else begin
            state_reg   <= state_next;
            db_reg      <= db_next;
            hold_reg    <= hold_next;
            mode_reg    <= mode_next;
            press_reg   <= press_next;
            long_reg    <= long_next;
            led_en_reg  <= led_en_next;
            cnt_max_reg <= cnt_max_next;
        end
    end

    assign press_pulse = press_reg;
    assign long_pulse  = long_reg;
    assign mode        = mode_reg;
    assign led_en      = led_en_reg;
    assign cnt_max     = cnt_max_reg;

endmodule

// File: tb/tb_key_mode_sel.sv
// Directed bench for key_mode_sel: expected strobes are queued as the key is
// driven and matched (cycle, kind, mode map) when the DUT strobes.
module tb_key_mode_sel;

    localparam logic [24:0] CNT_M1 = 25'd24999999;
    localparam logic [24:0] CNT_M2 = 25'd12499999;
    localparam logic [24:0] CNT_M3 = 25'd2499999;

    logic        clk50m = 1'b0;
    logic        rst    = 1'b1;
    logic        key_n  = 1'b1;
    logic        press_pulse, long_pulse, led_en;
    logic [1:0]  mode;
    logic [24:0] cnt_max;

    typedef struct {
        int kind;   // 0 = press strobe, 1 = long strobe
        int cyc;
        int md;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  exp_mode = 0;

    key_mode_sel #(
        .DB_MAX  (20'd4),
        .LONG_MAX(27'd50)
    ) dut (
        .clk50m     (clk50m),
        .rst        (rst),
        .key_n      (key_n),
        .press_pulse(press_pulse),
        .long_pulse (long_pulse),
        .mode       (mode),
        .led_en     (led_en),
        .cnt_max    (cnt_max)
    );

    always #10 clk50m = ~clk50m;
    always @(posedge clk50m) cyc = cyc + 1;

    function automatic logic [24:0] exp_cnt(int m);
        case (m)
            2:       return CNT_M2;
            3:       return CNT_M3;
            default: return CNT_M1;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(string tag, int m);
        chk({tag, "_mode"}, {30'd0, mode}, m);
        chk({tag, "_led_en"}, {31'd0, led_en}, (m != 0) ? 1 : 0);
        chk({tag, "_cnt_max"}, {7'd0, cnt_max}, {7'd0, exp_cnt(m)});
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk50m);
    endtask

    task automatic push_press(int delay);
        ev_t e;
        exp_mode = (exp_mode + 1) % 4;
        e.kind = 0; e.cyc = cyc + delay; e.md = exp_mode;
        q.push_back(e);
    endtask

    // Clean press: key low for 'low' cycles, then released for 'high' cycles.
    task automatic press(int low, int high);
        push_press(8);
        key_n = 1'b0;
        cycles(low);
        key_n = 1'b1;
        cycles(high);
    endtask

    // Scoreboard consumer: every strobe must match the oldest queued expectation.
    always @(negedge clk50m) begin
        if (press_pulse || long_pulse) begin
            chk("no_double_strobe", {31'd0, press_pulse & long_pulse}, 0);
            if (q.size() == 0) begin
                chk("unexpected_strobe", {30'd0, long_pulse, press_pulse}, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("strobe_kind", {31'd0, long_pulse}, e.kind);
                chk("strobe_press", {31'd0, press_pulse}, (e.kind == 0) ? 1 : 0);
                chk("strobe_cycle", cyc, e.cyc);
                chk_outputs("strobe", e.md);
            end
        end
    end

    initial begin
        ev_t e;
        // 1: long reset, key released
        cycles(200);
        chk_outputs("reset", 0);
        chk("reset_press", {31'd0, press_pulse}, 0);
        chk("reset_long", {31'd0, long_pulse}, 0);
        rst = 1'b0;
        cycles(10);
        chk_outputs("idle", 0);

        // 2: four clean presses walk 1,2,3,0
        for (int i = 0; i < 4; i++) begin
            press(30, 20);
            chk_outputs("step", exp_mode);
        end
        press(30, 20);
        chk_outputs("step_again", exp_mode);

        // 3: short glitches never complete the debounce
        for (int i = 0; i < 5; i++) begin
            key_n = 1'b0; cycles(3);
            key_n = 1'b1; cycles(3);
        end
        cycles(10);
        chk_outputs("glitch", exp_mode);

        // 4: from mode 2, long hold steps to 3 then forces 0 once
        press(30, 20);
        chk_outputs("pre_long", 2);
        push_press(8);
        e.kind = 1; e.cyc = cyc + 58; e.md = 0;
        q.push_back(e);
        key_n = 1'b0;
        cycles(100);
        exp_mode = 0;
        chk_outputs("long_hold", 0);
        key_n = 1'b1;
        cycles(20);
        chk_outputs("long_release", 0);

        // 5: release bounce is absorbed into a single press
        push_press(8);
        key_n = 1'b0; cycles(30);
        key_n = 1'b1; cycles(2);
        key_n = 1'b0; cycles(2);
        key_n = 1'b1; cycles(10);
        cycles(20);
        chk_outputs("bounce", exp_mode);

        // 6: reset while PRESSED with key still held
        push_press(8);
        key_n = 1'b0;
        cycles(15);
        rst = 1'b1;
        #1;
        chk_outputs("mid_reset", 0);
        chk("mid_reset_press", {31'd0, press_pulse}, 0);
        chk("mid_reset_long", {31'd0, long_pulse}, 0);
        cycles(3);
        rst = 1'b0;
        exp_mode = 0;
        push_press(8);
        cycles(30);
        key_n = 1'b1;
        cycles(20);
        chk_outputs("after_reset", 1);

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
